// File: rtl/ram_ctrl_pkg.sv
// Shared op codes and FSM state encodings for the RAM command controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ram_ctrl_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_WAIT   = 3'd1;
    localparam logic [2:0] ST_FILL      = 3'd2;
    localparam logic [2:0] ST_SCAN_WAIT = 3'd3;
    localparam logic [2:0] ST_SCAN_RD   = 3'd4;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, registered read, write-enable, no reset (M10K-inferable).
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
module ram_sp_sync #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_scan_ctrl.sv
// Command front-end over a single-port RAM: write, read, block fill and timed auto-scan read-out.
// Latency: READ result 2 cycles after accept; FILL busy DEPTH cycles; SCAN one read per SCAN_DIV+1 cycles.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored, never queued.
module ram_scan_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              scan_stop,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int                DIV_W     = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DATA_W-1:0] fill_val;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;

    // In scan states the RAM always looks at ptr, so the word for the next
    // SCAN_RD is already registered by the time that state is entered.
    always_comb begin
        ram_addr  = cmd_addr;
        ram_wdata = cmd_data;
        ram_we    = 1'b0;
        case (state)
            ST_IDLE:      ram_we = cmd_valid && (cmd_op == OP_WRITE);
            ST_FILL: begin
                ram_addr  = fill_cnt;
                ram_wdata = fill_val;
                ram_we    = 1'b1;
            end
            ST_SCAN_WAIT,
            ST_SCAN_RD:   ram_addr = ptr;
            default:      ;
        endcase
    end

    ram_sp_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            fill_cnt <= '0;
            div_cnt  <= '0;
            fill_val <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_READ: begin
                                ptr   <= cmd_addr;
                                state <= ST_RD_WAIT;
                            end
                            OP_FILL: begin
                                fill_cnt <= '0;
                                fill_val <= cmd_data;
                                state    <= ST_FILL;
                            end
                            OP_SCAN: begin
                                ptr   <= cmd_addr;
                                state <= ST_SCAN_RD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    rd_valid <= 1'b1;
                    rd_addr  <= ptr;
                    rd_data  <= ram_q;
                    state    <= ST_IDLE;
                end
                ST_FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == ADDR_LAST)
                        state <= ST_IDLE;
                end
                ST_SCAN_RD: begin
                    // A stop arriving with the read completion drops that read.
                    if (scan_stop) begin
                        state <= ST_IDLE;
                    end else begin
                        rd_valid <= 1'b1;
                        rd_addr  <= ptr;
                        rd_data  <= ram_q;
                        ptr      <= ptr + 1'b1;
                        div_cnt  <= '0;
                        state    <= ST_SCAN_WAIT;
                    end
                end
                ST_SCAN_WAIT: begin
                    if (scan_stop)
                        state <= ST_IDLE;
                    else if (div_cnt == DIV_LAST)
                        state <= ST_SCAN_RD;
                    else
                        div_cnt <= div_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl (32x4, SCAN_DIV=3) against a small memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_scan_ctrl;
    import ram_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [4:0] cmd_addr = '0;
    logic [3:0] cmd_data = '0;
    logic       scan_stop = 1'b0;
    logic       rd_valid;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;

    logic [3:0] model [32];
    int n_chk  = 0;
    int n_fail = 0;

    ram_scan_ctrl #(.DATA_W(4), .ADDR_W(5), .SCAN_DIV(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .scan_stop (scan_stop),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns one step after the accept edge (first cycle after accept).
    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [3:0] d);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        chk("cmd_ready_at_send", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d);
        send(OP_WRITE, a, d);
        model[a] = d;
        chk("write_no_vld", rd_valid, 0);
        chk("write_idle", busy, 0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [3:0] exp);
        send(OP_READ, a, 4'h0);
        chk("read_wait_vld", rd_valid, 0);
        chk("read_busy", busy, 1);
        step();
        chk("read_vld", rd_valid, 1);
        chk("read_addr", rd_addr, a);
        chk("read_data", rd_data, exp);
        step();
        chk("read_vld_pulse", rd_valid, 0);
    endtask

    task automatic do_fill(input logic [3:0] d, output int cycles, output logic saw_vld);
        send(OP_FILL, 5'd0, d);
        cycles  = 0;
        saw_vld = 1'b0;
        while (busy && cycles < 100) begin
            if (rd_valid) saw_vld = 1'b1;
            step();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic saw;
        logic [4:0] ea;

        // 1: reset state, FILL A, READ 7
        repeat (3) step();
        chk("rst_vld", rd_valid, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        resetn = 1'b1;
        step();
        do_fill(4'hA, cyc, saw);
        for (int i = 0; i < 32; i++) model[i] = 4'hA;
        chk("fill_cycles", cyc, 32);
        chk("fill_no_vld", saw, 0);
        chk("fill_ready", cmd_ready, 1);
        do_read(5'd7, model[7]);

        // 2: writes then reads back
        do_write(5'd17, 4'h5);
        do_write(5'd18, 4'hC);
        do_read(5'd17, 4'h5);
        do_read(5'd18, 4'hC);

        // 3 + 4: scan from 30 with wrap, then stop during SCAN_RD
        do_write(5'd30, 4'h6);
        do_write(5'd31, 4'h2);
        do_write(5'd0, 4'h9);
        do_write(5'd1, 4'h4);
        send(OP_SCAN, 5'd30, 4'h0);
        chk("scan_busy", busy, 1);
        for (int k = 1; k <= 13; k++) begin
            step();
            if ((k % 4) == 1) begin
                ea = 5'(30 + (k - 1) / 4);
                chk("scan_vld", rd_valid, 1);
                chk("scan_addr", rd_addr, ea);
                chk("scan_data", rd_data, model[ea]);
            end else begin
                chk("scan_gap_vld", rd_valid, 0);
            end
        end
        step();
        step();
        step();
        scan_stop = 1'b1;
        step();
        chk("stop_vld", rd_valid, 0);
        chk("stop_idle", busy, 0);
        chk("stop_addr_held", rd_addr, 1);
        chk("stop_data_held", rd_data, 4'h4);
        scan_stop = 1'b0;
        step();
        chk("stop_vld_after", rd_valid, 0);

        // 6: WRITE held during a scan only lands once back in IDLE
        send(OP_SCAN, 5'd1, 4'h0);
        cmd_op    = OP_WRITE;
        cmd_addr  = 5'd2;
        cmd_data  = 4'hF;
        cmd_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                chk("hold_scan_addr1", rd_addr, 1);
                chk("hold_scan_data1", rd_data, model[1]);
            end
            if (k == 5) begin
                chk("hold_scan_vld2", rd_valid, 1);
                chk("hold_scan_addr2", rd_addr, 2);
                chk("hold_scan_data2", rd_data, model[2]);
            end
        end
        chk("hold_ready_busy", cmd_ready, 0);
        scan_stop = 1'b1;
        step();
        chk("hold_ready_idle", cmd_ready, 1);
        scan_stop = 1'b0;
        step();
        cmd_valid = 1'b0;
        model[2] = 4'hF;
        chk("hold_write_no_vld", rd_valid, 0);
        do_read(5'd2, 4'hF);

        // 5: reset mid-FILL after 10 writes
        do_write(5'd20, 4'h3);
        send(OP_FILL, 5'd0, 4'h5);
        for (int k = 1; k <= 10; k++) step();
        chk("midfill_busy", busy, 1);
        for (int i = 0; i < 10; i++) model[i] = 4'h5;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_addr", rd_addr, 0);
        chk("midrst_data", rd_data, 0);
        chk("midrst_vld", rd_valid, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        do_read(5'd20, 4'h3);
        do_read(5'd9, model[9]);
        do_read(5'd10, model[10]);
        do_read(5'd0, model[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
